// File: rtl/display_scanner_pkg.sv
// Shared clock-display constants: segment codes, page encodings, snapshot layout.
// Combinational helpers only; no state, no latency.
package display_scanner_pkg;

    localparam int REFRESH_DIV_DEFAULT = 100000;

    localparam logic PAGE_TIME = 1'b0;
    localparam logic PAGE_DATE = 1'b1;

    // Active-low segment codes, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       page;
        logic [1:0] dhr;
        logic [3:0] uhr;
        logic [3:0] dmin;
        logic [3:0] umin;
        logic [2:0] dsec;
        logic [3:0] usec;
        logic [3:0] dec;
        logic [3:0] cen;
        logic [1:0] dday;
        logic [3:0] uday;
        logic       dmes;
        logic [3:0] umes;
    } snap_t;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Digit inputs and multiplexed display outputs of the scanner.
// Plain wires; no handshake, the display side never stalls.
interface display_scanner_if;
    logic       page;
    logic [3:0] centesimas;
    logic [3:0] decimas;
    logic [3:0] unidadesSegundo;
    logic [2:0] decenasSegundo;
    logic [3:0] unidadesMinuto;
    logic [3:0] decenasMinuto;
    logic [3:0] unidadesHora;
    logic [1:0] decenasHora;
    logic [3:0] unidadesDia;
    logic [1:0] decenasDia;
    logic [3:0] unidadesMes;
    logic       decenasMes;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output page, centesimas, decimas, unidadesSegundo, decenasSegundo,
               unidadesMinuto, decenasMinuto, unidadesHora, decenasHora,
               unidadesDia, decenasDia, unidadesMes, decenasMes,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  page, centesimas, decimas, unidadesSegundo, decenasSegundo,
               unidadesMinuto, decenasMinuto, unidadesHora, decenasHora,
               unidadesDia, decenasDia, unidadesMes, decenasMes,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/display_scanner_bcd_to_seg.sv
// Digit to 7-segment decoder with blank/dash overrides (blank wins).
// Purely combinational; no backpressure.
module bcd_to_seg
    import display_scanner_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        if (blank_i)     seg_o = SEG_BLANK;
        else if (dash_i) seg_o = SEG_DASH;
        else             seg_o = digit_seg(digit_i);
    end

endmodule

// File: rtl/display_scanner.sv
// Eight-digit multiplexed time/date scanner with per-frame input snapshot.
// Outputs registered, one cycle after idx/snapshot; free-running, no backpressure.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    snap_t         snap_q, snap_d, live;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;
    logic          cnt_last;

    logic [5:0]    day_bin;
    logic [4:0]    mon_bin;
    logic          day_bad, mon_bad, day_carry, mon_carry;
    logic [3:0]    day_t1, day_u1, mon_t1, mon_u1;
    logic [3:0]    dig;
    logic          blank, dash;

    always_comb begin
        live.page = bus.page;
        live.dhr  = bus.decenasHora;
        live.uhr  = bus.unidadesHora;
        live.dmin = bus.decenasMinuto;
        live.umin = bus.unidadesMinuto;
        live.dsec = bus.decenasSegundo;
        live.usec = bus.unidadesSegundo;
        live.dec  = bus.decimas;
        live.cen  = bus.centesimas;
        live.dday = bus.decenasDia;
        live.uday = bus.unidadesDia;
        live.dmes = bus.decenasMes;
        live.umes = bus.unidadesMes;
    end

    always_comb begin
        cnt_last = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d    = cnt_last ? '0 : cnt_q + CW'(1);
        idx_d    = cnt_last ? idx_q - 3'd1 : idx_q;
        tick_d   = cnt_last && (idx_q == 3'd0);
        snap_d   = ((cnt_q == '0) && (idx_q == 3'd7)) ? live : snap_q;
        an_d     = ~(8'd1 << idx_q);
    end

    // Date fields are shown 1-based; a non-BCD units digit is passed through so it decodes as a dash.
    always_comb begin
        day_bin   = 6'(snap_d.dday) * 6'd10 + 6'(snap_d.uday);
        mon_bin   = 5'(snap_d.dmes) * 5'd10 + 5'(snap_d.umes);
        day_bad   = day_bin > 6'd30;
        mon_bad   = mon_bin > 5'd11;
        day_carry = (snap_d.uday == 4'd9);
        mon_carry = (snap_d.umes == 4'd9);
        day_u1    = day_carry ? 4'd0 : ((snap_d.uday > 4'd9) ? snap_d.uday : snap_d.uday + 4'd1);
        mon_u1    = mon_carry ? 4'd0 : ((snap_d.umes > 4'd9) ? snap_d.umes : snap_d.umes + 4'd1);
        day_t1    = 4'(snap_d.dday) + 4'(day_carry);
        mon_t1    = 4'(snap_d.dmes) + 4'(mon_carry);
    end

    // Content follows snap_d so the first cycle of a frame already shows the fresh snapshot.
    always_comb begin
        dig   = 4'd0;
        blank = 1'b0;
        dash  = 1'b0;
        dp_d  = 1'b1;
        if (snap_d.page == PAGE_TIME) begin
            case (idx_q)
                3'd7: begin dig = {2'b00, snap_d.dhr}; blank = (snap_d.dhr == 2'd0); end
                3'd6: begin dig = snap_d.uhr; dp_d = 1'b0; end
                3'd5: dig = snap_d.dmin;
                3'd4: begin dig = snap_d.umin; dp_d = 1'b0; end
                3'd3: dig = {1'b0, snap_d.dsec};
                3'd2: begin dig = snap_d.usec; dp_d = 1'b0; end
                3'd1: dig = snap_d.dec;
                default: dig = snap_d.cen;
            endcase
        end else begin
            case (idx_q)
                3'd7: begin dig = day_t1; dash = day_bad; end
                3'd6: begin dig = day_u1; dash = day_bad; end
                3'd5: dash = 1'b1;
                3'd4: begin dig = mon_t1; dash = mon_bad; end
                3'd3: begin dig = mon_u1; dash = mon_bad; end
                default: blank = 1'b1;
            endcase
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .digit_i (dig),
        .blank_i (blank),
        .dash_i  (dash),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 3'd7;
            snap_q <= '0;
            an_q   <= 8'hFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner at REFRESH_DIV=4: vector table, corner sequences,
// and random frames against an arithmetic reference of the display rules.
module tb_display_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scanner_if bus();

    display_scanner #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       page;
        logic [1:0] dhr;
        logic [3:0] uhr, dmin, umin;
        logic [2:0] dsec;
        logic [3:0] usec, dec, cen;
        logic [1:0] dday;
        logic [3:0] uday;
        logic       dmes;
        logic [3:0] umes;
    } digits_t;

    typedef struct packed {
        logic [7:0][6:0] segs;
        logic [7:0]      dps;
    } frame_t;

    typedef struct {
        digits_t d;
        frame_t  f;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input digits_t x);
        bus.page            = x.page;
        bus.decenasHora     = x.dhr;
        bus.unidadesHora    = x.uhr;
        bus.decenasMinuto   = x.dmin;
        bus.unidadesMinuto  = x.umin;
        bus.decenasSegundo  = x.dsec;
        bus.unidadesSegundo = x.usec;
        bus.decimas         = x.dec;
        bus.centesimas      = x.cen;
        bus.decenasDia      = x.dday;
        bus.unidadesDia     = x.uday;
        bus.decenasMes      = x.dmes;
        bus.unidadesMes     = x.umes;
    endtask

    function automatic digits_t mk_time(input int h10, h1, m10, m1, s10, s1, d, c);
        digits_t x = '0;
        x.dhr = 2'(h10); x.uhr = 4'(h1); x.dmin = 4'(m10); x.umin = 4'(m1);
        x.dsec = 3'(s10); x.usec = 4'(s1); x.dec = 4'(d); x.cen = 4'(c);
        return x;
    endfunction

    function automatic digits_t mk_date(input int dd, du, md, mu);
        digits_t x = '0;
        x.page = 1'b1;
        x.dday = 2'(dd); x.uday = 4'(du); x.dmes = 1'(md); x.umes = 4'(mu);
        return x;
    endfunction

    function automatic digits_t rnd();
        digits_t x;
        x.page = 1'($urandom_range(0, 1));
        x.dhr  = 2'($urandom_range(0, 3));
        x.uhr  = 4'($urandom_range(0, 11));
        x.dmin = 4'($urandom_range(0, 11));
        x.umin = 4'($urandom_range(0, 11));
        x.dsec = 3'($urandom_range(0, 7));
        x.usec = 4'($urandom_range(0, 11));
        x.dec  = 4'($urandom_range(0, 11));
        x.cen  = 4'($urandom_range(0, 11));
        x.dday = 2'($urandom_range(0, 3));
        x.uday = 4'($urandom_range(0, 9));
        x.dmes = 1'($urandom_range(0, 1));
        x.umes = 4'($urandom_range(0, 9));
        return x;
    endfunction

    // v = -1 dash, -2 blank
    function automatic logic [6:0] code(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  -2: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic frame_t model(input digits_t x);
        frame_t f;
        int vals[8];
        int day, mon, n;
        f.dps = 8'hFF;
        if (x.page == 1'b0) begin
            vals[7] = int'(x.dhr);  vals[6] = int'(x.uhr);
            vals[5] = int'(x.dmin); vals[4] = int'(x.umin);
            vals[3] = int'(x.dsec); vals[2] = int'(x.usec);
            vals[1] = int'(x.dec);  vals[0] = int'(x.cen);
            for (int i = 0; i < 8; i++) f.segs[i] = (vals[i] > 9) ? code(-1) : code(vals[i]);
            if (vals[7] == 0) f.segs[7] = code(-2);
            f.dps[6] = 1'b0; f.dps[4] = 1'b0; f.dps[2] = 1'b0;
        end else begin
            day = 10 * int'(x.dday) + int'(x.uday);
            mon = 10 * int'(x.dmes) + int'(x.umes);
            if (day > 30) begin
                f.segs[7] = code(-1); f.segs[6] = code(-1);
            end else begin
                n = day + 1;
                f.segs[7] = code(n / 10); f.segs[6] = code(n % 10);
            end
            f.segs[5] = code(-1);
            if (mon > 11) begin
                f.segs[4] = code(-1); f.segs[3] = code(-1);
            end else begin
                n = mon + 1;
                f.segs[4] = code(n / 10); f.segs[3] = code(n % 10);
            end
            for (int i = 0; i < 3; i++) f.segs[i] = code(-2);
        end
        return f;
    endfunction

    task automatic add(input digits_t d, input logic [55:0] segs, input logic [7:0] dps);
        vec_t v;
        v.d = d;
        v.f.segs = segs;
        v.f.dps = dps;
        tbl.push_back(v);
    endtask

    // Called at the negedge of the cycle whose inputs the frame will capture.
    task automatic run_frame(input frame_t e, input int chg_step, input digits_t chg, input string tag);
        int idx;
        logic [7:0] an_exp;
        for (int s = 0; s < 32; s++) begin
            @(posedge clk);
            @(negedge clk);
            idx = 7 - s / 4;
            an_exp = ~(8'd1 << idx);
            chk($sformatf("%s an s%0d", tag, s), 32'(bus.an), 32'(an_exp));
            chk($sformatf("%s seg s%0d", tag, s), 32'(bus.seg), 32'(e.segs[idx]));
            chk($sformatf("%s dp s%0d", tag, s), 32'(bus.dp), 32'(e.dps[idx]));
            chk($sformatf("%s tick s%0d", tag, s), 32'(bus.frame_tick), 32'(s == 31));
            if (s == chg_step) drive(chg);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " an"}, 32'(bus.an), 32'h0FF);
        chk({tag, " seg"}, 32'(bus.seg), 32'h07F);
        chk({tag, " dp"}, 32'(bus.dp), 32'h1);
        chk({tag, " tick"}, 32'(bus.frame_tick), 32'h0);
    endtask

    initial begin
        digits_t a, b, c, cur, nx;

        rst = 1'b1;
        drive('0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_reset_outputs($sformatf("reset c%0d", i));
        end

        add(mk_time(2, 3, 5, 9, 5, 9, 9, 9),
            {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10, 7'h10, 7'h10}, 8'hAB);
        add(mk_time(0, 5, 1, 2, 3, 4, 5, 6),
            {7'h7F, 7'h12, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 8'hAB);
        add(mk_date(3, 0, 1, 1),
            {7'h30, 7'h79, 7'h3F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h7F}, 8'hFF);
        add(mk_date(0, 8, 0, 9),
            {7'h40, 7'h10, 7'h3F, 7'h79, 7'h40, 7'h7F, 7'h7F, 7'h7F}, 8'hFF);
        add(mk_date(3, 1, 1, 2),
            {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F, 7'h7F, 7'h7F}, 8'hFF);
        add(mk_date(0, 9, 0, 0),
            {7'h79, 7'h40, 7'h3F, 7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F}, 8'hFF);
        add(mk_time(1, 0, 12, 3, 4, 5, 6, 7),
            {7'h79, 7'h40, 7'h3F, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, 8'hAB);
        add(mk_date(2, 9, 1, 1),
            {7'h30, 7'h40, 7'h3F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h7F}, 8'hFF);

        rst = 1'b0;
        foreach (tbl[i]) begin
            drive(tbl[i].d);
            run_frame(tbl[i].f, -1, tbl[i].d, $sformatf("vec%0d", i));
        end

        // Mid-frame page toggle and minute change must wait for the next frame.
        a = mk_time(1, 2, 3, 4, 5, 6, 7, 8);
        b = a;
        b.page = 1'b1;
        b.umin = 4'd9;
        drive(a);
        run_frame(model(a), 16, b, "tear_hold");
        run_frame(model(b), -1, b, "tear_next");

        cur = rnd();
        drive(cur);
        for (int k = 0; k < 20; k++) begin
            nx = rnd();
            run_frame(model(cur), int'($urandom_range(0, 30)), nx, $sformatf("rand%0d", k));
            cur = nx;
        end

        // Reset while digit idx 3 is being scanned.
        drive(a);
        for (int s = 0; s < 17; s++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst an", 32'(bus.an), 32'h0F7);
        rst = 1'b1;
        c = rnd();
        drive(c);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_reset_outputs($sformatf("mid_rst c%0d", i));
        end
        rst = 1'b0;
        run_frame(model(c), -1, c, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
